// File: rtl/spi_cs_sequencer.sv
// spi_cs_sequencer
//   Chip-select transaction sequencer placed in front of the SPI byte engine.
//   Groups 1..MAX_BYTES_PER_CS bytes under one active-low CS assertion, forwards
//   user bytes under the engine's ready handshake, and returns received bytes
//   tagged with their index within the transaction. CS is held high for at
//   least CS_INACTIVE_CLKS cycles between transactions.
//   Build option: define SPI_CS_TIMEOUT_EN to add the idle-byte timeout and
//   the o_Timeout port.
module spi_cs_sequencer #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_INACTIVE_CLKS = 1,
  parameter int TIMEOUT_CLKS     = 1024,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic [CW-1:0] o_RX_Count,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic [7:0]    o_Eng_TX_Byte,
  output logic          o_Eng_TX_DV,
  input  logic          i_Eng_TX_Ready,
  input  logic          i_Eng_RX_DV,
  input  logic [7:0]    i_Eng_RX_Byte,
  output logic          o_SPI_CS_n
`ifdef SPI_CS_TIMEOUT_EN
  ,
  output logic          o_Timeout
`endif
);

  localparam int GW = $clog2(CS_INACTIVE_CLKS + 1);

  if (MAX_BYTES_PER_CS < 1 || CS_INACTIVE_CLKS < 1 || TIMEOUT_CLKS < 1) begin : g_param_check
    $error("spi_cs_sequencer: parameters must all be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    DRAIN,
    CS_GAP
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] bytes_left, bytes_left_nx;
  logic [CW-1:0] sent_cnt, sent_cnt_nx;
  logic [CW-1:0] rx_idx, rx_idx_nx;
  logic [GW-1:0] gap_cnt, gap_cnt_nx;
  logic          cs_n_nx;
  logic          eng_dv_nx;
  logic [7:0]    eng_byte_nx;
  logic          rx_dv_nx;
  logic [7:0]    rx_byte_nx;
  logic [CW-1:0] rx_count_nx;
  logic          eng_dv_d;
  logic          armed;
  logic          guard;
  logic          accept;

`ifdef SPI_CS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_cnt, to_cnt_nx;
  logic          timeout_nx;
`endif

  // Zero requests one byte; anything above the limit is cut to the limit.
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    if (c == '0) return CW'(1);
    if (c > CW'(MAX_BYTES_PER_CS)) return CW'(MAX_BYTES_PER_CS);
    return c;
  endfunction

  // Handshake: guard masks the engine's stale ready for two cycles after a start
  // pulse; armed keeps ready low while reset is held and for one cycle after.
  always_comb begin
    guard      = o_Eng_TX_DV | eng_dv_d;
    o_TX_Ready = armed & i_Eng_TX_Ready & ~guard &
                 ((state == IDLE) | ((state == TRANSFER) & (bytes_left != '0)));
    accept     = i_TX_DV & o_TX_Ready;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_nx      = state;
    bytes_left_nx = bytes_left;
    sent_cnt_nx   = sent_cnt;
    rx_idx_nx     = rx_idx;
    gap_cnt_nx    = gap_cnt;
    cs_n_nx       = o_SPI_CS_n;
    eng_dv_nx     = 1'b0;
    eng_byte_nx   = o_Eng_TX_Byte;
    rx_dv_nx      = 1'b0;
    rx_byte_nx    = o_RX_Byte;
    rx_count_nx   = o_RX_Count;
`ifdef SPI_CS_TIMEOUT_EN
    to_cnt_nx     = '0;
    timeout_nx    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          bytes_left_nx = clamp_count(i_TX_Count) - CW'(1);
          sent_cnt_nx   = CW'(1);
          rx_idx_nx     = '0;
          cs_n_nx       = 1'b0;
          eng_byte_nx   = i_TX_Byte;
          eng_dv_nx     = 1'b1;
          state_nx      = TRANSFER;
        end
      end
      TRANSFER: begin
        if (accept) begin
          bytes_left_nx = bytes_left - CW'(1);
          sent_cnt_nx   = sent_cnt + CW'(1);
          eng_byte_nx   = i_TX_Byte;
          eng_dv_nx     = 1'b1;
        end
        if (i_Eng_RX_DV) begin
          rx_dv_nx    = 1'b1;
          rx_byte_nx  = i_Eng_RX_Byte;
          rx_count_nx = rx_idx;
          rx_idx_nx   = rx_idx + CW'(1);
          if ((bytes_left == '0) && ((rx_idx + CW'(1)) == sent_cnt)) begin
            state_nx = DRAIN;
          end
        end
`ifdef SPI_CS_TIMEOUT_EN
        if ((bytes_left != '0) && i_Eng_TX_Ready && !accept) begin
          if (to_cnt == TW'(TIMEOUT_CLKS - 1)) begin
            timeout_nx    = 1'b1;
            bytes_left_nx = '0;
            cs_n_nx       = 1'b1;
            gap_cnt_nx    = GW'(CS_INACTIVE_CLKS - 1);
            state_nx      = CS_GAP;
          end else begin
            to_cnt_nx = to_cnt + TW'(1);
          end
        end
`endif
      end
      DRAIN: begin
        if (i_Eng_TX_Ready && !guard) begin
          cs_n_nx    = 1'b1;
          gap_cnt_nx = GW'(CS_INACTIVE_CLKS - 1);
          state_nx   = CS_GAP;
        end
      end
      CS_GAP: begin
        if (gap_cnt == '0) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt - GW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset raises CS without waiting for a clock.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state         <= IDLE;
      bytes_left    <= '0;
      sent_cnt      <= '0;
      rx_idx        <= '0;
      gap_cnt       <= '0;
      o_SPI_CS_n    <= 1'b1;
      o_Eng_TX_DV   <= 1'b0;
      o_Eng_TX_Byte <= '0;
      o_RX_DV       <= 1'b0;
      o_RX_Byte     <= '0;
      o_RX_Count    <= '0;
      eng_dv_d      <= 1'b0;
      armed         <= 1'b0;
`ifdef SPI_CS_TIMEOUT_EN
      to_cnt        <= '0;
      o_Timeout     <= 1'b0;
`endif
    end else begin
      state         <= state_nx;
      bytes_left    <= bytes_left_nx;
      sent_cnt      <= sent_cnt_nx;
      rx_idx        <= rx_idx_nx;
      gap_cnt       <= gap_cnt_nx;
      o_SPI_CS_n    <= cs_n_nx;
      o_Eng_TX_DV   <= eng_dv_nx;
      o_Eng_TX_Byte <= eng_byte_nx;
      o_RX_DV       <= rx_dv_nx;
      o_RX_Byte     <= rx_byte_nx;
      o_RX_Count    <= rx_count_nx;
      eng_dv_d      <= o_Eng_TX_DV;
      armed         <= 1'b1;
`ifdef SPI_CS_TIMEOUT_EN
      to_cnt        <= to_cnt_nx;
      o_Timeout     <= timeout_nx;
`endif
    end
  end

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// tb_spi_cs_sequencer: directed bench for spi_cs_sequencer with a loopback SPI
// engine model and a scoreboard of expected engine and RX bytes.
// Define SPI_CS_TIMEOUT_EN to also exercise the idle-byte timeout.
module tb_spi_cs_sequencer;

  localparam int MAXB = 2;
  localparam int GAP  = 1;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] tx_count = '0;
  logic [7:0]    tx_byte = '0;
  logic          tx_dv = 1'b0;
  logic          tx_ready;
  logic [CW-1:0] rx_count;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic [7:0]    eng_tx_byte;
  logic          eng_tx_dv;
  logic          eng_ready;
  logic          eng_rx_dv;
  logic [7:0]    eng_rx_byte;
  logic          cs_n;
`ifdef SPI_CS_TIMEOUT_EN
  logic          timeout;
`endif

  spi_cs_sequencer #(
    .MAX_BYTES_PER_CS(MAXB),
    .CS_INACTIVE_CLKS(GAP)
`ifdef SPI_CS_TIMEOUT_EN
    , .TIMEOUT_CLKS(16)
`endif
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_TX_Count    (tx_count),
    .i_TX_Byte     (tx_byte),
    .i_TX_DV       (tx_dv),
    .o_TX_Ready    (tx_ready),
    .o_RX_Count    (rx_count),
    .o_RX_DV       (rx_dv),
    .o_RX_Byte     (rx_byte),
    .o_Eng_TX_Byte (eng_tx_byte),
    .o_Eng_TX_DV   (eng_tx_dv),
    .i_Eng_TX_Ready(eng_ready),
    .i_Eng_RX_DV   (eng_rx_dv),
    .i_Eng_RX_Byte (eng_rx_byte),
    .o_SPI_CS_n    (cs_n)
`ifdef SPI_CS_TIMEOUT_EN
    , .o_Timeout   (timeout)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loopback engine: ready drops one cycle after it sees the start pulse,
  // the byte comes back a few cycles later, ready returns after the last edge.
  int         eng_cnt;
  logic [7:0] eng_hold;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt     <= 0;
      eng_hold    <= '0;
      eng_ready   <= 1'b1;
      eng_rx_dv   <= 1'b0;
      eng_rx_byte <= '0;
    end else begin
      eng_rx_dv <= 1'b0;
      if (eng_tx_dv) begin
        eng_cnt  <= 1;
        eng_hold <= eng_tx_byte;
      end else if (eng_cnt != 0) begin
        if (eng_cnt == 1) eng_ready <= 1'b0;
        if (eng_cnt == 5) begin
          eng_rx_dv   <= 1'b1;
          eng_rx_byte <= eng_hold;
        end
        if (eng_cnt == 8) begin
          eng_ready <= 1'b1;
          eng_cnt   <= 0;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
    end
  end

  // Scoreboard queues filled when a byte is accepted.
  logic [7:0]    exp_eng[$];
  logic [7:0]    exp_rx_byte[$];
  logic [CW-1:0] exp_rx_idx[$];
  logic [CW-1:0] rx_idx_exp;

  int n_eng_dv = 0, n_rx = 0, n_cs_fall = 0, n_cs_rise = 0;
  logic prev_dv = 1'b0, prev_cs = 1'b1, txn_open = 1'b0;
  int   hi_cnt = 0;

  // Monitor on the falling edge: scoreboard pops plus CS/guard invariants.
  always @(negedge clk) begin
    if (rst) begin
      prev_dv  = 1'b0;
      prev_cs  = 1'b1;
      txn_open = 1'b0;
      hi_cnt   = 0;
    end else begin
      if (eng_tx_dv) begin
        n_eng_dv++;
        check("eng_cs_low", 32'(cs_n), 32'd0);
        if (exp_eng.size() == 0) check("eng_unexpected", 32'd1, 32'd0);
        else check("eng_byte", 32'(eng_tx_byte), 32'(exp_eng.pop_front()));
      end
      if (eng_tx_dv || prev_dv) check("guard_ready", 32'(tx_ready), 32'd0);
      if (rx_dv) begin
        n_rx++;
        if (exp_rx_byte.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
        else begin
          check("rx_byte", 32'(rx_byte), 32'(exp_rx_byte.pop_front()));
          check("rx_count", 32'(rx_count), 32'(exp_rx_idx.pop_front()));
        end
      end
      if (!cs_n && prev_cs) begin
        n_cs_fall++;
        txn_open = 1'b1;
        hi_cnt   = 0;
      end
      if (cs_n && !prev_cs) begin
        n_cs_rise++;
        check("cs_rise_eng_ready", 32'(eng_ready), 32'd1);
        check("cs_rise_rx_done", 32'(exp_rx_byte.size()), 32'd0);
      end
      if (cs_n && txn_open) begin
        if (tx_ready) begin
          check("cs_gap_len", 32'(hi_cnt >= GAP), 32'd1);
          txn_open = 1'b0;
        end else begin
          hi_cnt++;
        end
      end
      prev_dv = eng_tx_dv;
      prev_cs = cs_n;
    end
  end

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cs"},       32'(cs_n),        32'd1);
    check({pfx, "_ready"},    32'(tx_ready),    32'd0);
    check({pfx, "_rx_dv"},    32'(rx_dv),       32'd0);
    check({pfx, "_rx_byte"},  32'(rx_byte),     32'd0);
    check({pfx, "_rx_count"}, 32'(rx_count),    32'd0);
    check({pfx, "_eng_dv"},   32'(eng_tx_dv),   32'd0);
    check({pfx, "_eng_byte"}, 32'(eng_tx_byte), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [CW-1:0] cnt);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tx_ready) begin ok = 1'b1; break; end
    end
    check("ready_wait", 32'(ok), 32'd1);
    if (!ok) return;
    tx_count = cnt;
    tx_byte  = b;
    tx_dv    = 1'b1;
    exp_eng.push_back(b);
    exp_rx_byte.push_back(b);
    exp_rx_idx.push_back(rx_idx_exp);
    rx_idx_exp = rx_idx_exp + CW'(1);
    @(posedge clk); #1;
    tx_dv = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cs_n && tx_ready) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  int b_dv, b_rx, b_fall, b_rise;

  task automatic mark();
    b_dv = n_eng_dv; b_rx = n_rx; b_fall = n_cs_fall; b_rise = n_cs_rise;
  endtask

  task automatic check_deltas(input string tag, input int nbytes);
    check({tag, "_eng_dv_n"},  32'(n_eng_dv - b_dv),    32'(nbytes));
    check({tag, "_rx_n"},      32'(n_rx - b_rx),        32'(nbytes));
    check({tag, "_cs_fall_n"}, 32'(n_cs_fall - b_fall), 32'd1);
    check({tag, "_cs_rise_n"}, 32'(n_cs_rise - b_rise), 32'd1);
  endtask

  initial begin
    rx_idx_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    #3 rst = 1'b0;

    // Single byte.
    mark(); rx_idx_exp = '0;
    send_byte(8'hA5, CW'(1));
    wait_idle("single_idle");
    check_deltas("single", 1);

    // Two bytes under one CS.
    mark(); rx_idx_exp = '0;
    send_byte(8'h12, CW'(2));
    send_byte(8'h34, CW'(2));
    wait_idle("two_idle");
    check_deltas("two", 2);

    // Count 0 behaves as 1.
    mark(); rx_idx_exp = '0;
    send_byte(8'h3C, CW'(0));
    wait_idle("zero_idle");
    check_deltas("zero", 1);

    // Count 3 clamps to 2.
    mark(); rx_idx_exp = '0;
    send_byte(8'h81, CW'(3));
    send_byte(8'h7E, CW'(3));
    wait_idle("clamp_idle");
    check_deltas("clamp", 2);

    // Strobes during DRAIN / CS_GAP are ignored.
    mark(); rx_idx_exp = '0;
    send_byte(8'hE7, CW'(1));
    begin
      bit seen = 1'b0;
      int strobes = 0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk); #1;
        if (n_rx != b_rx) begin seen = 1'b1; break; end
      end
      check("ign_rx_wait", 32'(seen), 32'd1);
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        tx_dv = 1'b0;
        if (tx_ready) break;
        tx_byte = 8'hFF;
        tx_dv   = 1'b1;
        strobes++;
      end
      tx_dv = 1'b0;
      check("ign_strobed", 32'(strobes > 0), 32'd1);
    end
    wait_idle("ign_idle");
    check_deltas("ign", 1);

    // Reset in the middle of a two-byte transaction.
    rx_idx_exp = '0;
    send_byte(8'h11, CW'(2));
    repeat (2) @(posedge clk);
    #1;
    check("mid_cs_low", 32'(cs_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    exp_eng.delete();
    exp_rx_byte.delete();
    exp_rx_idx.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Normal transaction after reset.
    mark(); rx_idx_exp = '0;
    send_byte(8'h5A, CW'(2));
    send_byte(8'hC3, CW'(2));
    wait_idle("post_idle");
    check_deltas("post", 2);

`ifdef SPI_CS_TIMEOUT_EN
    // Send 1 of 2 bytes, then go quiet until the timeout fires.
    mark(); rx_idx_exp = '0;
    send_byte(8'h66, CW'(2));
    begin
      bit rdy = 1'b0, fired = 1'b0;
      int cyc = 0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      for (int i = 0; i < 50; i++) begin
        @(posedge clk); #1;
        if (eng_ready) begin rdy = 1'b1; break; end
      end
      check("to_eng_ready", 32'(rdy), 32'd1);
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        cyc++;
        if (timeout) begin fired = 1'b1; break; end
      end
      check("to_fired", 32'(fired), 32'd1);
      check("to_delay", 32'(cyc >= 16 && cyc <= 17), 32'd1);
      check("to_cs_high", 32'(cs_n), 32'd1);
    end
    wait_idle("to_idle");
    check_deltas("to", 1);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
